// File: rtl/vec_pe_pkg.sv
// Shared types and constants for the vector PE sequencer.
// Optional perf counters are enabled with VEC_PE_SEQ_PERF_EN.
package vec_pe_pkg;

  localparam int CMD_VL_W = 16;

  localparam logic [1:0] VSEW_8  = 2'd0;
  localparam logic [1:0] VSEW_16 = 2'd1;
  localparam logic [1:0] VSEW_32 = 2'd2;

  localparam logic [1:0] WIDEN_NONE = 2'd0;
  localparam logic [1:0] WIDEN_2X   = 2'd1;
  localparam logic [1:0] WIDEN_4X   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [CMD_VL_W-1:0] vl;
    logic [1:0]          vsew;
    logic [1:0]          widening;
    logic                wide_b;
    logic                reduce;
  } vec_cmd_t;

  // Width combinations the PE sign-extension/multiply path cannot build.
  function automatic logic cmd_illegal(
    input logic [1:0] vsew,
    input logic [1:0] widening,
    input logic       wide_b
  );
    return (vsew == 2'd3)
        || (widening == 2'd3)
        || (widening[1] && vsew != VSEW_8)
        || (widening[0] && vsew == VSEW_32)
        || (wide_b && vsew == VSEW_32);
  endfunction

endpackage

// File: rtl/vec_pe_lane_mask.sv
// Per-lane active mask and last-step flag for one element group.
// Arithmetic is widened so the largest vl never wraps.
module vec_pe_lane_mask
  import vec_pe_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int VL_W   = 8
) (
  input  logic [VL_W:0]         idx,
  input  logic [CMD_VL_W-1:0]   vl,
  output logic [NUM_PE-1:0]     mask,
  output logic                  last
);

  localparam int AW = CMD_VL_W + 2;

  logic [AW-1:0] base;
  logic [AW-1:0] vl_x;

  assign base = AW'(idx);
  assign vl_x = AW'(vl);

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      mask[i] = (base + AW'(i)) < vl_x;
    end
  end

  assign last = (base + AW'(NUM_PE)) >= vl_x;

endmodule

// File: rtl/vec_pe_sequencer.sv
// Steps one vector command across the PE lanes, one group per step.
// VEC_PE_SEQ_PERF_EN adds saturating stall/step counters.
module vec_pe_sequencer
  import vec_pe_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int VL_W       = 8,
  parameter int REDUCE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [VL_W-1:0]   cmd_vl_i,
  input  logic [1:0]        cmd_vsew_i,
  input  logic [1:0]        cmd_widening_i,
  input  logic              cmd_wide_b_i,
  input  logic              cmd_reduce_i,
  output logic              step_valid_o,
  input  logic              step_ready_i,
  output logic [VL_W-1:0]   step_idx_o,
  output logic [NUM_PE-1:0] step_mask_o,
  output logic              step_last_o,
  output logic [1:0]        pe_vsew_o,
  output logic [1:0]        pe_widening_o,
  output logic              pe_wide_b_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              illegal_o
`ifdef VEC_PE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_steps_o
`endif
);

  seq_state_e      state;
  vec_cmd_t        cmd_q;
  vec_cmd_t        cmd_in;
  logic [VL_W:0]   idx;
  logic            ill_q;
  logic [3:0]      drain_cnt;
  logic            in_ill;
  logic            hs;

  always_comb begin
    cmd_in          = '0;
    cmd_in.vl       = CMD_VL_W'(cmd_vl_i);
    cmd_in.vsew     = cmd_vsew_i;
    cmd_in.widening = cmd_widening_i;
    cmd_in.wide_b   = cmd_wide_b_i;
    cmd_in.reduce   = cmd_reduce_i;
  end

  assign in_ill = cmd_illegal(cmd_vsew_i, cmd_widening_i, cmd_wide_b_i);

  vec_pe_lane_mask #(
    .NUM_PE (NUM_PE),
    .VL_W   (VL_W)
  ) u_mask (
    .idx  (idx),
    .vl   (cmd_q.vl),
    .mask (step_mask_o),
    .last (step_last_o)
  );

  assign hs = (state == S_STEP) && step_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      idx       <= '0;
      ill_q     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            cmd_q <= cmd_in;
            idx   <= '0;
            ill_q <= in_ill;
            if (in_ill || cmd_vl_i == '0) state <= S_DONE;
            else                          state <= S_STEP;
          end
        end
        S_STEP: begin
          if (hs) begin
            if (!step_last_o) begin
              idx <= idx + (VL_W+1)'(NUM_PE);
            end else if (cmd_q.reduce) begin
              drain_cnt <= 4'(REDUCE_LAT);
              state     <= S_DRAIN;
            end else begin
              state <= S_DONE;
            end
          end
        end
        // Counter holds REDUCE_LAT drain cycles; leave on the last one.
        S_DRAIN: begin
          if (drain_cnt <= 4'd1) state <= S_DONE;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (state == S_IDLE);
  assign step_valid_o  = (state == S_STEP);
  assign busy_o        = (state != S_IDLE);
  assign done_o        = (state == S_DONE);
  assign illegal_o     = (state == S_DONE) && ill_q;
  assign step_idx_o    = idx[VL_W-1:0];
  assign pe_vsew_o     = cmd_q.vsew;
  assign pe_widening_o = cmd_q.widening;
  assign pe_wide_b_o   = cmd_q.wide_b;

`ifdef VEC_PE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_o <= '0;
      perf_steps_o <= '0;
    end else begin
      if (step_valid_o && !step_ready_i && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 32'd1;
      if (hs && perf_steps_o != '1)
        perf_steps_o <= perf_steps_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_pe_sequencer.sv
// Table-driven bench with a step scoreboard for vec_pe_sequencer.
// Perf counters are checked when VEC_PE_SEQ_PERF_EN is defined.
module tb_vec_pe_sequencer;
  import vec_pe_pkg::*;

  localparam int NUM_PE     = 4;
  localparam int VL_W       = 8;
  localparam int REDUCE_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [VL_W-1:0]   cmd_vl_i;
  logic [1:0]        cmd_vsew_i;
  logic [1:0]        cmd_widening_i;
  logic              cmd_wide_b_i;
  logic              cmd_reduce_i;
  logic              step_valid_o;
  logic              step_ready_i;
  logic [VL_W-1:0]   step_idx_o;
  logic [NUM_PE-1:0] step_mask_o;
  logic              step_last_o;
  logic [1:0]        pe_vsew_o;
  logic [1:0]        pe_widening_o;
  logic              pe_wide_b_o;
  logic              busy_o;
  logic              done_o;
  logic              illegal_o;
`ifdef VEC_PE_SEQ_PERF_EN
  logic [31:0]       perf_stall_o;
  logic [31:0]       perf_steps_o;
`endif

  always #5 clk = ~clk;

  vec_pe_sequencer #(
    .NUM_PE     (NUM_PE),
    .VL_W       (VL_W),
    .REDUCE_LAT (REDUCE_LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_vl_i       (cmd_vl_i),
    .cmd_vsew_i     (cmd_vsew_i),
    .cmd_widening_i (cmd_widening_i),
    .cmd_wide_b_i   (cmd_wide_b_i),
    .cmd_reduce_i   (cmd_reduce_i),
    .step_valid_o   (step_valid_o),
    .step_ready_i   (step_ready_i),
    .step_idx_o     (step_idx_o),
    .step_mask_o    (step_mask_o),
    .step_last_o    (step_last_o),
    .pe_vsew_o      (pe_vsew_o),
    .pe_widening_o  (pe_widening_o),
    .pe_wide_b_o    (pe_wide_b_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .illegal_o      (illegal_o)
`ifdef VEC_PE_SEQ_PERF_EN
    ,
    .perf_stall_o   (perf_stall_o),
    .perf_steps_o   (perf_steps_o)
`endif
  );

  typedef struct {
    int vl;
    int vsew;
    int wid;
    int wb;
    int red;
    int stall;
    int ill;
  } vec_t;

  typedef struct {
    int idx;
    int mask;
    int last;
  } step_t;

  step_t sb[$];
  vec_t  tbl[11];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_steps(input int vl);
    step_t s;
    for (int b = 0; b < vl; b += NUM_PE) begin
      s.idx  = b;
      s.mask = 0;
      for (int i = 0; i < NUM_PE; i++)
        if (b + i < vl) s.mask |= (1 << i);
      s.last = (b + NUM_PE >= vl) ? 1 : 0;
      sb.push_back(s);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int cyc, last_hs, first_v, stall_left, nsteps, exp_done;
    int held_idx, held_mask;
    bit held, done_seen;
    step_t e;
`ifdef VEC_PE_SEQ_PERF_EN
    int st0, sp0;
`endif
    sb.delete();
    if (!v.ill) push_steps(v.vl);
    nsteps = sb.size();
    @(negedge clk);
    chk("cmd_ready_idle", int'(cmd_ready_o), 1);
`ifdef VEC_PE_SEQ_PERF_EN
    st0 = int'(perf_stall_o);
    sp0 = int'(perf_steps_o);
`endif
    cmd_vl_i       = VL_W'(v.vl);
    cmd_vsew_i     = 2'(v.vsew);
    cmd_widening_i = 2'(v.wid);
    cmd_wide_b_i   = 1'(v.wb);
    cmd_reduce_i   = 1'(v.red);
    cmd_valid_i    = 1'b1;
    step_ready_i   = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cyc = 1; last_hs = -1; first_v = -1;
    stall_left = v.stall; held = 0; done_seen = 0;
    while (!done_seen && cyc < 400) begin
      if (step_valid_o && first_v < 0) first_v = cyc;
      if (step_valid_o && stall_left > 0) begin
        step_ready_i = 1'b0;
        stall_left--;
        if (held) begin
          chk("stall_idx_hold", int'(step_idx_o), held_idx);
          chk("stall_mask_hold", int'(step_mask_o), held_mask);
        end
        held = 1;
        held_idx = int'(step_idx_o);
        held_mask = int'(step_mask_o);
      end else begin
        step_ready_i = 1'b1;
      end
      if (v.red && v.wb) chk("wide_b_hold", int'(pe_wide_b_o), 1);
      if (step_valid_o && step_ready_i) begin
        held = 0;
        last_hs = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("step_idx", int'(step_idx_o), e.idx);
          chk("step_mask", int'(step_mask_o), e.mask);
          chk("step_last", int'(step_last_o), e.last);
        end
      end
      if (done_o) begin
        done_seen = 1;
        if (nsteps == 0) exp_done = 1;
        else exp_done = last_hs + (v.red ? REDUCE_LAT + 1 : 1);
        chk("done_cycle", cyc, exp_done);
        chk("illegal", int'(illegal_o), v.ill);
        chk("cmd_ready_done", int'(cmd_ready_o), 0);
        chk("pe_vsew", int'(pe_vsew_o), v.vsew);
        chk("pe_widening", int'(pe_widening_o), v.wid);
        chk("pe_wide_b", int'(pe_wide_b_o), v.wb);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    chk("steps_left", sb.size(), 0);
    if (nsteps > 0) chk("first_valid_cycle", first_v, 1);
    @(negedge clk);
    chk("done_pulse_end", int'(done_o), 0);
    chk("illegal_pulse_end", int'(illegal_o), 0);
    chk("ready_after_done", int'(cmd_ready_o), 1);
`ifdef VEC_PE_SEQ_PERF_EN
    chk("perf_stall", int'(perf_stall_o) - st0, v.stall);
    chk("perf_steps", int'(perf_steps_o) - sp0, nsteps);
`endif
  endtask

  initial begin
    int hs_cnt, guard;
    tbl[0]  = '{vl: 10,  vsew: 0, wid: 0, wb: 0, red: 0, stall: 0, ill: 0};
    tbl[1]  = '{vl: 8,   vsew: 1, wid: 0, wb: 0, red: 0, stall: 3, ill: 0};
    tbl[2]  = '{vl: 5,   vsew: 1, wid: 2, wb: 0, red: 0, stall: 0, ill: 1};
    tbl[3]  = '{vl: 5,   vsew: 3, wid: 0, wb: 0, red: 0, stall: 0, ill: 1};
    tbl[4]  = '{vl: 5,   vsew: 2, wid: 0, wb: 1, red: 0, stall: 0, ill: 1};
    tbl[5]  = '{vl: 0,   vsew: 0, wid: 0, wb: 0, red: 0, stall: 0, ill: 0};
    tbl[6]  = '{vl: 4,   vsew: 0, wid: 0, wb: 1, red: 1, stall: 0, ill: 0};
    tbl[7]  = '{vl: 255, vsew: 0, wid: 1, wb: 0, red: 0, stall: 0, ill: 0};
    tbl[8]  = '{vl: 7,   vsew: 2, wid: 1, wb: 0, red: 0, stall: 0, ill: 1};
    tbl[9]  = '{vl: 3,   vsew: 2, wid: 0, wb: 0, red: 1, stall: 2, ill: 0};
    tbl[10] = '{vl: 9,   vsew: 0, wid: 3, wb: 0, red: 0, stall: 0, ill: 1};

    reset = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_vl_i = '0;
    cmd_vsew_i = '0;
    cmd_widening_i = '0;
    cmd_wide_b_i = 1'b0;
    cmd_reduce_i = 1'b0;
    step_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready_o), 1);
    chk("rst_valid", int'(step_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_pe", int'({pe_vsew_o, pe_widening_o, pe_wide_b_o}), 0);
    reset = 1'b0;

    for (int t = 0; t < 11; t++) run_cmd(tbl[t]);

    // Reset in the middle of a 16-element command after two steps.
    @(negedge clk);
    cmd_vl_i = 8'd16;
    cmd_vsew_i = 2'd1;
    cmd_widening_i = 2'd0;
    cmd_wide_b_i = 1'b0;
    cmd_reduce_i = 1'b0;
    cmd_valid_i = 1'b1;
    step_ready_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    hs_cnt = 0;
    guard = 0;
    while (hs_cnt < 2 && guard < 20) begin
      if (step_valid_o) begin
        chk("mid_idx", int'(step_idx_o), hs_cnt * NUM_PE);
        hs_cnt++;
      end
      if (hs_cnt < 2) @(negedge clk);
      guard++;
    end
    chk("mid_two_steps", hs_cnt, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", int'(cmd_ready_o), 1);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_valid", int'(step_valid_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    chk("mid_rst_vsew", int'(pe_vsew_o), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_done", int'(done_o), 0);
    end
    run_cmd('{vl: 6, vsew: 1, wid: 0, wb: 0, red: 0, stall: 1, ill: 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
